// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALUOp codes, forwarding selects and the control bundle
// that travels with an instruction through the ID/EX, EX/MEM and MEM/WB registers.
package pipe_ctrl_pkg;

  localparam int CTRL_OPC_W   = 6;
  localparam int CTRL_REG_AW  = 5;
  localparam int CTRL_ALUOP_W = 2;

  localparam logic [CTRL_OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [CTRL_OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [CTRL_OPC_W-1:0] OP_BNE   = 6'b000110;
  localparam logic [CTRL_OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [CTRL_OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [CTRL_OPC_W-1:0] OP_J     = 6'b100110;
  localparam logic [CTRL_OPC_W-1:0] OP_ADDI  = 6'b101000;

  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_RTYPE  = 2'b00;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD    = 2'b10;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;

  typedef struct packed {
    logic                    reg_dst;
    logic                    alu_src;
    logic                    branch;
    logic                    bt;
    logic                    jump;
    logic [CTRL_ALUOP_W-1:0] alu_op;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t                  ctrl;
    logic [CTRL_REG_AW-1:0] dest;
    logic [CTRL_REG_AW-1:0] rs;
    logic [CTRL_REG_AW-1:0] rt;
  } id_ex_t;

  typedef struct packed {
    ctrl_t                  ctrl;
    logic [CTRL_REG_AW-1:0] dest;
  } stage_t;

  // Register 0 is hard-wired, so it never produces a dependency.
  function automatic logic src_hit(input logic [CTRL_REG_AW-1:0] src,
                                   input logic [CTRL_REG_AW-1:0] dest,
                                   input logic                   wr);
    return wr && (dest != '0) && (dest == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [CTRL_REG_AW-1:0] src,
                                         input logic                   mem_wr,
                                         input logic [CTRL_REG_AW-1:0] mem_dest,
                                         input logic                   wb_wr,
                                         input logic [CTRL_REG_AW-1:0] wb_dest);
    if (src_hit(src, mem_dest, mem_wr)) return FWD_EX_MEM;
    if (src_hit(src, wb_dest, wb_wr))   return FWD_MEM_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_control_hazard_unit.sv
// Combinational hazard logic: stall, ID/EX bubble, IF/ID flush and forwarding selects.
// PIPE_CTRL_FORWARDING_EN enables forwarding; otherwise RAW on EX/MEM dests stalls.
module pipe_hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic                   reset,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_is_jump,
  input  logic [CTRL_REG_AW-1:0] id_rs,
  input  logic [CTRL_REG_AW-1:0] id_rt,
  input  logic                   ex_mem_read,
  input  logic                   ex_reg_write,
  input  logic                   ex_branch,
  input  logic                   ex_branch_taken,
  input  logic [CTRL_REG_AW-1:0] ex_dest,
  input  logic [CTRL_REG_AW-1:0] ex_rs,
  input  logic [CTRL_REG_AW-1:0] ex_rt,
  input  logic                   mem_reg_write,
  input  logic [CTRL_REG_AW-1:0] mem_dest,
  input  logic                   wb_reg_write,
  input  logic [CTRL_REG_AW-1:0] wb_dest,
  output logic                   pc_stall,
  output logic                   bubble,
  output logic                   if_id_flush,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b
);

  logic taken;
  logic load_use;
  logic hazard;

`ifdef PIPE_CTRL_FORWARDING_EN
  logic unused_fwd_build;
  assign unused_fwd_build = ex_reg_write;
`else
  logic unused_nofwd_build;
  assign unused_nofwd_build = ^{ex_rs, ex_rt, wb_reg_write, wb_dest};
`endif

  always_comb begin
    taken    = ex_branch && ex_branch_taken;
    load_use = ex_mem_read &&
               ((id_use_rs && src_hit(id_rs, ex_dest, 1'b1)) ||
                (id_use_rt && src_hit(id_rt, ex_dest, 1'b1)));
`ifdef PIPE_CTRL_FORWARDING_EN
    hazard = load_use;
    fwd_a  = fwd_sel(ex_rs, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
    fwd_b  = fwd_sel(ex_rt, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
`else
    // Write-before-read register file: only EX and MEM producers matter.
    hazard = load_use ||
             (id_use_rs && (src_hit(id_rs, ex_dest, ex_reg_write) ||
                            src_hit(id_rs, mem_dest, mem_reg_write))) ||
             (id_use_rt && (src_hit(id_rt, ex_dest, ex_reg_write) ||
                            src_hit(id_rt, mem_dest, mem_reg_write)));
    fwd_a  = FWD_RF;
    fwd_b  = FWD_RF;
`endif
    // A taken branch squashes the ID instruction, so its stall is moot.
    pc_stall    = !reset && hazard && !taken;
    if_id_flush = !reset && (taken || (id_is_jump && !hazard));
    bubble      = taken || hazard;
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined main control: decodes in ID and carries the bundle through EX, MEM, WB.
// Define PIPE_CTRL_FORWARDING_EN to drive fwd_a/fwd_b and stall only on load-use.
module pipe_control
  import pipe_ctrl_pkg::*;
#(
  parameter int OPC_W   = CTRL_OPC_W,
  parameter int REG_AW  = CTRL_REG_AW,
  parameter int ALUOP_W = CTRL_ALUOP_W
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [OPC_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_branch_taken,
  output logic               pc_stall,
  output logic               if_id_flush,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic               ex_Branch,
  output logic               ex_BT,
  output logic               ex_Jump,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [REG_AW-1:0]  wb_dest,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               err_illegal
);

  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_dest;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_illegal;
  logic              bubble;

  id_ex_t id_ex_d,  id_ex_q;
  stage_t ex_mem_d, ex_mem_q;
  stage_t mem_wb_d, mem_wb_q;
  logic   err_d,    err_q;

  always_comb begin
    id_ctrl    = CTRL_BUBBLE;
    id_dest    = '0;
    id_use_rs  = 1'b0;
    id_use_rt  = 1'b0;
    id_illegal = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        OP_RTYPE: begin
          id_ctrl.reg_dst   = 1'b1;
          id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_op    = ALUOP_RTYPE;
          id_dest           = id_rd;
          id_use_rs         = 1'b1;
          id_use_rt         = 1'b1;
        end
        OP_BEQ: begin
          id_ctrl.branch = 1'b1;
          id_ctrl.alu_op = ALUOP_BRANCH;
          id_use_rs      = 1'b1;
          id_use_rt      = 1'b1;
        end
        OP_BNE: begin
          id_ctrl.branch = 1'b1;
          id_ctrl.bt     = 1'b1;
          id_ctrl.alu_op = ALUOP_BRANCH;
          id_use_rs      = 1'b1;
          id_use_rt      = 1'b1;
        end
        OP_LW: begin
          id_ctrl.mem_read   = 1'b1;
          id_ctrl.mem_to_reg = 1'b1;
          id_ctrl.alu_src    = 1'b1;
          id_ctrl.reg_write  = 1'b1;
          id_ctrl.alu_op     = ALUOP_ADD;
          id_dest            = id_rt;
          id_use_rs          = 1'b1;
        end
        OP_SW: begin
          id_ctrl.mem_write = 1'b1;
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.alu_op    = ALUOP_ADD;
          id_use_rs         = 1'b1;
          id_use_rt         = 1'b1;
        end
        OP_J: begin
          id_ctrl.jump = 1'b1;
        end
        OP_ADDI: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_op    = ALUOP_ADD;
          id_dest           = id_rt;
          id_use_rs         = 1'b1;
        end
        default: id_illegal = 1'b1;
      endcase
      if (id_dest == '0) id_ctrl.reg_write = 1'b0;
    end
  end

  // Unused source fields are zeroed so they can never trigger a forward.
  always_comb begin
    id_ex_d = '0;
    if (!bubble) begin
      id_ex_d.ctrl = id_ctrl;
      id_ex_d.dest = id_dest;
      id_ex_d.rs   = id_use_rs ? id_rs : '0;
      id_ex_d.rt   = id_use_rt ? id_rt : '0;
    end
    ex_mem_d = '{ctrl: id_ex_q.ctrl, dest: id_ex_q.dest};
    mem_wb_d = ex_mem_q;
    err_d    = err_q | id_illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      err_q    <= 1'b0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      err_q    <= err_d;
    end
  end

  pipe_hazard_unit u_hazard (
    .reset           (reset),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_is_jump      (id_ctrl.jump),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_mem_read     (id_ex_q.ctrl.mem_read),
    .ex_reg_write    (id_ex_q.ctrl.reg_write),
    .ex_branch       (id_ex_q.ctrl.branch),
    .ex_branch_taken (ex_branch_taken),
    .ex_dest         (id_ex_q.dest),
    .ex_rs           (id_ex_q.rs),
    .ex_rt           (id_ex_q.rt),
    .mem_reg_write   (ex_mem_q.ctrl.reg_write),
    .mem_dest        (ex_mem_q.dest),
    .wb_reg_write    (mem_wb_q.ctrl.reg_write),
    .wb_dest         (mem_wb_q.dest),
    .pc_stall        (pc_stall),
    .bubble          (bubble),
    .if_id_flush     (if_id_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  assign ex_RegDst    = id_ex_q.ctrl.reg_dst;
  assign ex_ALUSrc    = id_ex_q.ctrl.alu_src;
  assign ex_Branch    = id_ex_q.ctrl.branch;
  assign ex_BT        = id_ex_q.ctrl.bt;
  assign ex_Jump      = id_ex_q.ctrl.jump;
  assign ex_ALUOp     = id_ex_q.ctrl.alu_op;
  assign mem_MemRead  = ex_mem_q.ctrl.mem_read;
  assign mem_MemWrite = ex_mem_q.ctrl.mem_write;
  assign wb_RegWrite  = mem_wb_q.ctrl.reg_write;
  assign wb_MemtoReg  = mem_wb_q.ctrl.mem_to_reg;
  assign wb_dest      = mem_wb_q.dest;
  assign err_illegal  = err_q;

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Five-stage pipelined successor to the single-cycle main control decoder.
- Decodes the opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and RAW hazards, generates stall, bubble and flush controls, and optionally drives forwarding selects.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
- OPC_W, 6, opcode width.
- REG_AW, 5, register-address width.
- ALUOP_W, 2, ALUOp width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  OPC_W  opcode in ID.
- id_rs  in  REG_AW  rs field in ID.
- id_rt  in  REG_AW  rt field in ID.
- id_rd  in  REG_AW  rd field in ID.
- ex_branch_taken  in  1  EX comparator result; qualified internally by ex_Branch.
- pc_stall  out  1  hold PC and IF/ID.
- if_id_flush  out  1  zero IF/ID next edge.
- ex_RegDst, ex_ALUSrc, ex_Branch, ex_BT, ex_Jump  out  1 each  EX-stage controls.
- ex_ALUOp  out  ALUOP_W  EX-stage ALU operation.
- mem_MemRead, mem_MemWrite  out  1 each  MEM-stage controls.
- wb_RegWrite, wb_MemtoReg  out  1 each  WB-stage controls.
- wb_dest  out  REG_AW  WB destination register.
- fwd_a, fwd_b  out  2 each  forwarding selects: 00 register file, 10 EX/MEM, 01 MEM/WB.
- err_illegal  out  1  sticky unknown-opcode flag.

Behaviour:
- Opcode decode:
  - 000000 R-type: RegDst, RegWrite, ALUOp 00, dest = rd.
  - 000100 beq: Branch, ALUOp 01.
  - 000110 bne: Branch, BT, ALUOp 01.
  - 100011 lw: MemRead, MemtoReg, ALUSrc, RegWrite, ALUOp 10, dest = rt.
  - 101011 sw: MemWrite, ALUSrc, ALUOp 10.
  - 100110 j: Jump.
  - 101000 addi: ALUSrc, RegWrite, ALUOp 10, dest = rt.
  - Any other opcode: all-zero bubble, and err_illegal is set when id_valid=1.
- Register-$0 rule: RegWrite is forced to 0 whenever dest==0. No hazard or forwarding is ever raised on register 0.
- Source usage: rs is used by every opcode except j. rt is used by R-type, beq, bne and sw.
- Latency: an instruction in ID at cycle t drives ex_* at t+1, mem_* at t+2, and wb_*/wb_dest at t+3.
- Pipeline registers: id_ex, ex_mem and mem_wb hold the control bundle plus dest. id_ex additionally holds rs and rt.
- Reset: every stage register clears to a bubble (all zero). All outputs read 0 the cycle after reset is sampled high, and err_illegal clears.
  - Reset mid-operation discards all in-flight control.
- Load-use hazard: ex_MemRead && ex_dest!=0 && ex_dest matches a used ID source. Response:
  - pc_stall=1.
  - id_ex loads a bubble.
  - IF/ID holds.
  - Stall lasts exactly 1 cycle.
- Jump in ID with id_valid: if_id_flush=1 for one cycle. The jump itself proceeds to EX.
- Taken branch (ex_Branch && ex_branch_taken): if_id_flush=1 and id_ex loads a bubble, discarding the ID instruction.
- Priority: reset > taken-branch flush > stall > normal.
  - A branch flush coinciding with a load-use stall cancels the stall (pc_stall=0).
  - A jump in ID during a stall waits; no flush is issued until the stall clears.
- id_valid=0 decodes as a bubble with no hazard check.
- All hazard outputs (pc_stall, if_id_flush) are combinational from the current state and ID inputs. Stage registers update only on the clk edge.

Optional Feature:
- Macro: PIPE_CTRL_FORWARDING_EN.
- Defined:
  - fwd_a/fwd_b are computed combinationally for the EX-stage rs/rt.
  - Priority is EX/MEM (10) over MEM/WB (01); each requires RegWrite && dest!=0 && dest==source.
  - Only load-use hazards stall.
- Undefined:
  - fwd_a/fwd_b are tied to 00.
  - pc_stall is asserted whenever a used ID source matches the ex or mem stage dest with RegWrite (dest!=0).
  - The stall repeats every cycle until cleared, i.e. up to 2 cycles. The register file is write-before-read, so WB is not a hazard.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J, OP_ADDI);
  - ALUOp constants;
  - packed struct ctrl_t for the control bundle;
  - a constant CTRL_BUBBLE.
- Sub-module pipe_hazard_unit: combinational; computes pc_stall, bubble, if_id_flush and fwd_a/fwd_b.
- Decode and the stage registers stay in the top module.

Test Plan:
- Reset, then lw / R-type / sw / addi, back to back, no dependencies -> per-stage controls appear at t+1/t+2/t+3 with the exact decode values, and pc_stall stays 0.
- lw $2, then add $3,$2,$4 -> exactly one pc_stall cycle, then ex_* shows a bubble; with FORWARDING_EN, fwd_a=01 when the add reaches EX.
- add $5,..., then sub $6,$5,$5 -> FORWARDING_EN: fwd_a=fwd_b=10 with no stall; without: pc_stall for 2 cycles and fwd outputs 00.
- beq with ex_branch_taken=1 -> if_id_flush=1 and the next ex_* is all zero; bne with ex_branch_taken=0 -> no flush.
- j (100110) in ID -> if_id_flush for 1 cycle and ex_Jump=1 the next cycle; opcode 111111 -> err_illegal stays 1 until reset and no control bits are set.
- addi $0 -> wb_RegWrite=0 and no forward or stall on a following reader of $0; reset asserted mid-stall -> all outputs 0 next cycle.
